// File: rtl/aux_ade_regen_pkg.sv
// rtl/aux_ade_regen_pkg.sv - shared constants, FSM states and header check for the aux data-island regenerator
package aux_ade_regen_pkg;

  localparam int H_TOTAL   = 1650;  // pixels per line
  localparam int BURST_LEN = 32;    // aux words (= ade cycles) per data island
  localparam int MAX_BURST = 10;    // bursts allowed to start per line

  localparam int HCNT_W    = 11;
  localparam int WORD_W    = 24;
  localparam int BEAT_W    = $clog2(BURST_LEN);
  localparam int LINE_W    = 4;

  // Field positions inside a FIFO word {hpos[11:0], aux[11:0]}
  localparam int HPOS_MSB  = 23;
  localparam int HPOS_LSB  = 12;
  localparam int AUX_MSB   = 11;
  localparam int AUX_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_FILL,
    ST_WAIT,
    ST_BURST
  } state_t;

  // A header is unusable when the spare bit is set or it points past the line end.
  function automatic logic hpos_bad(input logic [11:0] hpos);
    return hpos[11] || (hpos[10:0] >= HCNT_W'(H_TOTAL));
  endfunction

endpackage

// File: rtl/aux_ade_regen_if.sv
// rtl/aux_ade_regen_if.sv - timing, aux FIFO read side and encoder side of the regenerator
interface aux_ade_regen_if;
  import aux_ade_regen_pkg::*;

  logic [HCNT_W-1:0] hcnt;      // horizontal pixel counter
  logic              vde;       // video data enable
  logic              ax_empty;  // recv aux FIFO empty
  logic [WORD_W-1:0] axdout;    // recv aux FIFO Q, valid the cycle after ax_rd_en
  logic              ax_rd_en;  // FIFO read strobe
  logic              ade;       // aux data enable to encoder
  logic [3:0]        aux0;      // aux[3:0]
  logic [3:0]        aux1;      // aux[7:4]
  logic [3:0]        aux2;      // aux[11:8]
  logic [LINE_W-1:0] ade_num;   // bursts started in the previous line
  logic              underrun;  // sticky FIFO underrun during a burst
  logic              hdr_err;   // sticky bad header

  modport slave (
    input  hcnt, vde, ax_empty, axdout,
    output ax_rd_en, ade, aux0, aux1, aux2, ade_num, underrun, hdr_err
  );

  modport master (
    output hcnt, vde, ax_empty, axdout,
    input  ax_rd_en, ade, aux0, aux1, aux2, ade_num, underrun, hdr_err
  );

endinterface

// File: rtl/aux_ade_regen.sv
// rtl/aux_ade_regen.sv - replays 32-word aux bursts as ade/aux nibbles at the header hpos during blanking
//
// Ports:
//   fifo_clk  in  pixel clock, the only clock
//   sys_rst   in  asynchronous active-high reset
//   aux_bus   slave modport: hcnt/vde timing, ax_empty/axdout/ax_rd_en FIFO
//             read side, ade/aux0..2 encoder side, ade_num/underrun/hdr_err status
module aux_ade_regen
  import aux_ade_regen_pkg::*;
(
  input  logic            fifo_clk,
  input  logic            sys_rst,
  aux_ade_regen_if.slave  aux_bus
);

  state_t            r_state;
  state_t            w_next;
  logic [11:0]       r_hpos;
  logic [BEAT_W-1:0] r_beat;
  logic [LINE_W-1:0] r_line_cnt;
  logic [LINE_W-1:0] r_ade_num;
  logic              r_dry;       // a data read of the current burst was skipped
  logic              r_ade;
  logic [11:0]       r_aux;
  logic              r_underrun;
  logic              r_hdr_err;

  logic              w_match;
  logic              w_rd;
  logic              w_last;
  logic              w_hdr_bad;

  assign w_match   = (r_state == ST_WAIT) && !aux_bus.vde &&
                     (aux_bus.hcnt == r_hpos[10:0]) &&
                     (r_line_cnt < LINE_W'(MAX_BURST));
  assign w_last    = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_hdr_bad = hpos_bad(aux_bus.axdout[HPOS_MSB:HPOS_LSB]);

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (aux_bus.vde) w_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (!aux_bus.ax_empty) begin
          w_rd   = 1'b1;
          w_next = ST_FILL;
        end
      end
      ST_FILL: begin
        w_next = w_hdr_bad ? ST_PRIME : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_match) begin
          w_rd   = !aux_bus.ax_empty;
          w_next = ST_BURST;
        end
      end
      ST_BURST: begin
        w_rd = !aux_bus.ax_empty;
        // The last-beat read is the next burst's word0; only a clean burst
        // whose prefetch succeeded may skip straight to FILL.
        if (w_last) w_next = (!r_dry && !aux_bus.ax_empty) ? ST_FILL : ST_PRIME;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge fifo_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_hpos     <= '0;
      r_beat     <= '0;
      r_line_cnt <= '0;
      r_ade_num  <= '0;
      r_dry      <= 1'b0;
      r_ade      <= 1'b0;
      r_aux      <= '0;
      r_underrun <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_ade <= 1'b0;
      r_aux <= '0;

      if (r_state == ST_FILL) begin
        r_hpos <= aux_bus.axdout[HPOS_MSB:HPOS_LSB];
        if (w_hdr_bad) r_hdr_err <= 1'b1;
      end

      // Match cycle: word0 already sits on axdout from the PRIME/prefetch read.
      if (w_match) begin
        r_ade  <= 1'b1;
        r_aux  <= aux_bus.axdout[AUX_MSB:AUX_LSB];
        r_beat <= BEAT_W'(1);
        r_dry  <= aux_bus.ax_empty;
        if (aux_bus.ax_empty) r_underrun <= 1'b1;
      end

      if (r_state == ST_BURST) begin
        r_ade  <= 1'b1;
        r_aux  <= r_dry ? 12'h000 : aux_bus.axdout[AUX_MSB:AUX_LSB];
        r_beat <= r_beat + BEAT_W'(1);
        // A missing prefetch on the last beat is not an underrun of this burst.
        if (!w_last && aux_bus.ax_empty) begin
          r_dry      <= 1'b1;
          r_underrun <= 1'b1;
        end
      end

      if (aux_bus.hcnt == '0) begin
        r_ade_num  <= r_line_cnt;
        r_line_cnt <= w_match ? LINE_W'(1) : '0;
      end else if (w_match) begin
        r_line_cnt <= r_line_cnt + LINE_W'(1);
      end
    end
  end

  assign aux_bus.ax_rd_en = w_rd;
  assign aux_bus.ade      = r_ade;
  assign aux_bus.aux0     = r_aux[3:0];
  assign aux_bus.aux1     = r_aux[7:4];
  assign aux_bus.aux2     = r_aux[11:8];
  assign aux_bus.ade_num  = r_ade_num;
  assign aux_bus.underrun = r_underrun;
  assign aux_bus.hdr_err  = r_hdr_err;

endmodule

// File: tb/tb_aux_ade_regen.sv
// tb/tb_aux_ade_regen.sv - scoreboard bench for aux_ade_regen with a 1-cycle-latency FIFO model
module tb_aux_ade_regen;
  import aux_ade_regen_pkg::*;

  typedef struct packed {
    logic [10:0] hc;
    logic [11:0] aux;
  } exp_t;

  logic fifo_clk;
  logic sys_rst;
  aux_ade_regen_if bus();

  aux_ade_regen dut (
    .fifo_clk (fifo_clk),
    .sys_rst  (sys_rst),
    .aux_bus  (bus)
  );

  exp_t        exp_q[$];
  logic [23:0] fifo_q[$];
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          ade_seen = 0;
  logic        rd_s;

  initial begin
    fifo_clk = 1'b0;
    forever #5 fifo_clk = ~fifo_clk;
  end

  // FIFO model and hcnt generator: inputs change 1 time unit after the edge.
  initial begin
    bus.hcnt     = '0;
    bus.vde      = 1'b0;
    bus.ax_empty = 1'b1;
    bus.axdout   = '0;
    forever begin
      @(negedge fifo_clk);
      rd_s = bus.ax_rd_en;
      @(posedge fifo_clk);
      #1;
      if (rd_s && fifo_q.size() > 0) begin
        bus.axdout = fifo_q.pop_front();
        rd_cnt++;
      end
      bus.ax_empty = (fifo_q.size() == 0);
      bus.hcnt = (bus.hcnt == 11'(H_TOTAL - 1)) ? 11'd0 : bus.hcnt + 11'd1;
    end
  end

  // Monitor: every ade cycle is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge fifo_clk);
      if (bus.ax_rd_en) begin
        total++;
        if (bus.ax_empty) begin
          bad++;
          $display("FAIL rd_while_empty actual=1 required=0 hcnt=%0d", bus.hcnt);
        end
      end
      if (bus.ade) begin
        ade_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ade hcnt=%0d aux=%03h required=no ade", bus.hcnt,
                   {bus.aux2, bus.aux1, bus.aux0});
        end else begin
          e = exp_q.pop_front();
          if ({bus.hcnt, bus.aux2, bus.aux1, bus.aux0} !== {e.hc, e.aux}) begin
            bad++;
            $display("FAIL beat actual hcnt=%0d aux=%03h required hcnt=%0d aux=%03h",
                     bus.hcnt, {bus.aux2, bus.aux1, bus.aux0}, e.hc, e.aux);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fifo_clk);
      #2;
    end
  endtask

  task automatic wait_hcnt(input logic [10:0] v);
    int n = 0;
    do begin
      @(posedge fifo_clk);
      #2;
      n++;
    end while (bus.hcnt != v && n < 2 * H_TOTAL);
    if (bus.hcnt != v) begin
      total++;
      bad++;
      $display("FAIL wait_hcnt actual=%0d required=%0d", bus.hcnt, v);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge fifo_clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d left required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_words(input logic [11:0] hpos, input logic [11:0] base, input int n);
    fifo_q.push_back({hpos, base});
    for (int k = 1; k < n; k++) fifo_q.push_back({12'h000, base + 12'(k)});
    bus.ax_empty = 1'b0;
  endtask

  task automatic exp_burst(input logic [11:0] hpos, input logic [11:0] base,
                           input int ndata, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      exp_t e;
      e.hc  = hpos[10:0] + 11'(1 + k);
      e.aux = (k < ndata) ? base + 12'(k) : 12'h000;
      exp_q.push_back(e);
    end
  endtask

  task automatic vde_pulse();
    bus.vde = 1'b1;
    tick(1);
    bus.vde = 1'b0;
  endtask

  initial begin
    int r0;
    int a0;
    sys_rst = 1'b1;
    tick(3);
    chk("rst_ade", 32'(bus.ade), 32'd0);
    chk("rst_rd_en", 32'(bus.ax_rd_en), 32'd0);
    chk("rst_aux", 32'({bus.aux2, bus.aux1, bus.aux0}), 32'd0);
    chk("rst_ade_num", 32'(bus.ade_num), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_hdr_err", 32'(bus.hdr_err), 32'd0);
    sys_rst = 1'b0;

    // 1: single burst, idle until the first vde
    push_words(12'h05A, 12'h000, 32);
    exp_burst(12'h05A, 12'h000, 32, 32);
    tick(5);
    chk("idle_no_read", 32'(rd_cnt), 32'd0);
    vde_pulse();
    wait_drain(4 * H_TOTAL);
    tick(2);
    chk("t1_reads", 32'(rd_cnt), 32'd32);

    // 2: two bursts back to back on one line
    wait_hcnt(11'd2);
    r0 = rd_cnt;
    push_words(12'h05A, 12'h100, 32);
    push_words(12'h100, 12'h200, 32);
    exp_burst(12'h05A, 12'h100, 32, 32);
    exp_burst(12'h100, 12'h200, 32, 32);
    wait_drain(4 * H_TOTAL);
    tick(2);
    chk("t2_reads", 32'(rd_cnt - r0), 32'd64);
    wait_hcnt(11'd1);
    chk("t2_ade_num", 32'(bus.ade_num), 32'd2);
    chk("t2_underrun", 32'(bus.underrun), 32'd0);

    // 3: FIFO runs dry at beat 10
    wait_hcnt(11'd2);
    r0 = rd_cnt;
    push_words(12'h040, 12'h300, 10);
    exp_burst(12'h040, 12'h300, 10, 32);
    wait_drain(4 * H_TOTAL);
    chk("t3_underrun", 32'(bus.underrun), 32'd1);
    chk("t3_reads", 32'(rd_cnt - r0), 32'd10);
    push_words(12'h080, 12'h400, 32);
    exp_burst(12'h080, 12'h400, 32, 32);
    wait_drain(4 * H_TOTAL);

    // 4: bad headers are dropped
    wait_hcnt(11'd2);
    chk("t4_hdr_err_pre", 32'(bus.hdr_err), 32'd0);
    r0 = rd_cnt;
    fifo_q.push_back({12'h700, 12'hABC});
    fifo_q.push_back({12'h810, 12'hDEF});
    push_words(12'h0C0, 12'h500, 32);
    exp_burst(12'h0C0, 12'h500, 32, 32);
    wait_drain(4 * H_TOTAL);
    tick(2);
    chk("t4_hdr_err", 32'(bus.hdr_err), 32'd1);
    chk("t4_reads", 32'(rd_cnt - r0), 32'd34);

    // 5a: no burst while vde is high across hpos
    wait_hcnt(11'd1000);
    bus.vde = 1'b1;
    push_words(12'h020, 12'h600, 32);
    exp_burst(12'h020, 12'h600, 32, 32);
    a0 = ade_seen;
    wait_hcnt(11'd100);
    chk("t5_vde_block", 32'(ade_seen - a0), 32'd0);
    bus.vde = 1'b0;
    wait_drain(4 * H_TOTAL);

    // 5b: eleven bursts queued, only ten start per line
    wait_hcnt(11'd1200);
    for (int i = 0; i < 11; i++) begin
      push_words(12'(16 + 48 * i), 12'(32 * i), 32);
      exp_burst(12'(16 + 48 * i), 12'(32 * i), 32, 32);
    end
    wait_hcnt(11'd1);
    wait_hcnt(11'd1000);
    wait_hcnt(11'd1);
    chk("t5_ade_num_max", 32'(bus.ade_num), 32'd10);
    wait_drain(4 * H_TOTAL);
    wait_hcnt(11'd1000);
    wait_hcnt(11'd1);
    chk("t5_ade_num_next", 32'(bus.ade_num), 32'd1);

    // 6: asynchronous reset in the middle of a burst
    push_words(12'h030, 12'h700, 32);
    exp_burst(12'h030, 12'h700, 32, 15);
    wait_drain(4 * H_TOTAL);
    chk("t6_pre_rst_ade", 32'(bus.ade), 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("t6_rst_ade", 32'(bus.ade), 32'd0);
    chk("t6_rst_rd_en", 32'(bus.ax_rd_en), 32'd0);
    chk("t6_rst_aux", 32'({bus.aux2, bus.aux1, bus.aux0}), 32'd0);
    tick(3);
    sys_rst = 1'b0;
    chk("t6_underrun_clr", 32'(bus.underrun), 32'd0);
    chk("t6_hdr_err_clr", 32'(bus.hdr_err), 32'd0);
    chk("t6_ade_num_clr", 32'(bus.ade_num), 32'd0);
    r0 = rd_cnt;
    a0 = ade_seen;
    tick(400);
    chk("t6_idle_reads", 32'(rd_cnt - r0), 32'd0);
    chk("t6_idle_ade", 32'(ade_seen - a0), 32'd0);
    fifo_q.delete();
    bus.ax_empty = 1'b1;
    r0 = rd_cnt;
    push_words(12'h050, 12'h7A0, 32);
    exp_burst(12'h050, 12'h7A0, 32, 32);
    vde_pulse();
    wait_drain(4 * H_TOTAL);
    tick(2);
    chk("t6_reads", 32'(rd_cnt - r0), 32'd32);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
